// File: rtl/dpwm_deadtime_gen.sv
// Digital PWM generator with complementary high-side/low-side gate drive.
// Programmable rising/falling deadtimes, double-buffered duty/deadtime
// shadows loaded at the period boundary, run enable and sticky fault
// shutdown with a resume hold that suppresses partial periods.
//
// Handshake/timing contract: there is no valid/ready traffic here. Inputs
// duty_in/dt_rise/dt_fall are sampled into shadows on every clock while
// en=0, or on the last count of a period while en=1. Gate outputs follow
// the compare result of the current count with exactly one clock of latency.
module dpwm_deadtime_gen #(
  parameter int CNT_W = 6,
  parameter int DT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [DT_W-1:0]  dt_rise,
  input  logic [DT_W-1:0]  dt_fall,
  input  logic             fault,
  input  logic             fault_clr,
  output logic             hs_out,
  output logic             ls_out,
  output logic [CNT_W-1:0] count,
  output logic             period_start,
  output logic             fault_latched
);

  // One past the last count, held in CNT_W+1 bits so compare sums never wrap.
  localparam logic [CNT_W:0]   PERIOD  = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] duty_s;
  logic [DT_W-1:0]  dtr_s;
  logic [DT_W-1:0]  dtf_s;
  logic             resume;

  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   ls_lo;
  logic [CNT_W:0]   ls_hi;
  logic             hs_on;
  logic             ls_on;
  logic             run;
  logic             shadow_load;
  logic             clear_evt;
  logic             at_zero;

  // Compare windows, load strobe and gate qualifier derived from current state.
  always_comb begin
    cnt_ext     = {1'b0, count};
    ls_lo       = {1'b0, duty_s} + {{(CNT_W+1-DT_W){1'b0}}, dtr_s};
    ls_hi       = PERIOD - {{(CNT_W+1-DT_W){1'b0}}, dtf_s};
    hs_on       = (cnt_ext < {1'b0, duty_s});
    ls_on       = (cnt_ext >= ls_lo) && (cnt_ext < ls_hi);
    at_zero     = (count == '0);
    shadow_load = !en || (count == CNT_MAX);
    clear_evt   = fault_latched && fault_clr && !fault;
    // Raw fault term gates immediately; resume only releases at count 0.
    run         = en && !fault_latched && !fault && !(resume && !at_zero);
  end

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // Shadow registers: mid-period command changes wait for the next period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_s <= '0;
      dtr_s  <= '0;
      dtf_s  <= '0;
    end else if (shadow_load) begin
      duty_s <= duty_in;
      dtr_s  <= dt_rise;
      dtf_s  <= dt_fall;
    end
  end

  // Sticky fault latch; a simultaneous fault request wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_latched <= 1'b0;
    end else if (fault) begin
      fault_latched <= 1'b1;
    end else if (fault_clr) begin
      fault_latched <= 1'b0;
    end
  end

  // Resume hold: set on fault clear, released when the counter reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resume <= 1'b0;
    end else if (clear_evt) begin
      resume <= 1'b1;
    end else if (at_zero) begin
      resume <= 1'b0;
    end
  end

  // Registered gate drives and period marker, one clock behind the compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_out       <= 1'b0;
      ls_out       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      hs_out       <= hs_on && run;
      ls_out       <= ls_on && run;
      period_start <= en && at_zero;
    end
  end

endmodule

// File: tb/tb_dpwm_deadtime_gen.sv
// Testbench for dpwm_deadtime_gen: table-driven period waveforms, hand
// sequences for duty update, fault/clear, enable drop and async reset, then
// randomized stimulus against a behavioural reference model.
module tb_dpwm_deadtime_gen;
  localparam int CNT_W = 6;
  localparam int DT_W  = 4;
  localparam int N     = 64;
  localparam int W     = CNT_W + 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             en, fault, fault_clr;
  logic [CNT_W-1:0] duty_in;
  logic [DT_W-1:0]  dt_rise, dt_fall;
  logic             hs_out, ls_out, period_start, fault_latched;
  logic [CNT_W-1:0] count;

  dpwm_deadtime_gen #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
    .dt_rise(dt_rise), .dt_fall(dt_fall), .fault(fault), .fault_clr(fault_clr),
    .hs_out(hs_out), .ls_out(ls_out), .count(count),
    .period_start(period_start), .fault_latched(fault_latched)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           dtr_q[$];
  int           dtf_q[$];
  bit           blk_q[$];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int req);
    n_tests++;
    if (act < req) begin
      n_fail++;
      $display("FAIL %s: gap %0d below required %0d", name, act, req);
    end
  endtask

  // Gates must never overlap while out of reset.
  always @(negedge clk) begin
    if (rst) begin
      n_tests++;
      if (hs_out && ls_out) begin
        n_fail++;
        $display("FAIL overlap: hs_out=%0d ls_out=%0d required not both 1", hs_out, ls_out);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target);
    int k = 0;
    while (int'(count) != target && k < 200) begin
      step();
      k++;
    end
    if (int'(count) != target) check("wait_count timeout", int'(count), target);
  endtask

  // Steps until count==target, requiring both gates off on the way.
  task automatic hold_off_until(input int target, input string name);
    int k = 0;
    while (k < 200) begin
      step();
      k++;
      if (int'(count) == target) break;
      check({name, " hs off"}, int'(hs_out), 0);
      check({name, " ls off"}, int'(ls_out), 0);
    end
    if (int'(count) != target) check({name, " timeout"}, int'(count), target);
  endtask

  // Samples 64 clocks; outputs reflect the previous count (idx = count-1).
  task automatic run_period(input string name, input int hs_n, input int ls_lo, input int ls_hi);
    for (int i = 0; i < N; i++) begin
      int idx;
      step();
      idx = (int'(count) + N - 1) % N;
      check($sformatf("%s hs@%0d", name, idx), int'(hs_out), int'(idx < hs_n));
      check($sformatf("%s ls@%0d", name, idx), int'(ls_out), int'(idx >= ls_lo && idx < ls_hi));
      check($sformatf("%s ps@%0d", name, idx), int'(period_start), int'(idx == 0));
    end
  endtask

  task automatic start_run(input int d, input int r, input int f);
    en = 1'b0;
    duty_in = CNT_W'(d);
    dt_rise = DT_W'(r);
    dt_fall = DT_W'(f);
    step();
    step();
    en = 1'b1;
  endtask

  // Table-driven vectors
  typedef struct {
    int duty;
    int dtr;
    int dtf;
    int hs_n;
    int ls_lo;
    int ls_hi;
  } vec_t;
  vec_t tbl[7];

  // Reference model state
  int m_cnt, m_duty, m_dtr, m_dtf;
  bit m_flt, m_res;

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_dtr = 0; m_dtf = 0; m_flt = 0; m_res = 0;
  endtask

  // Computes the post-edge outputs for the current inputs and advances the model.
  task automatic model_step();
    bit gate_ok, hs_n, ls_n, ps_n;
    int pos;
    pos     = m_cnt;
    gate_ok = en && !m_flt && !fault && !(m_res && pos != 0);
    hs_n    = gate_ok && (pos < m_duty);
    ls_n    = gate_ok && (pos >= m_duty + m_dtr) && (pos < N - m_dtf);
    ps_n    = en && (pos == 0);
    dtr_q.push_back(m_dtr);
    dtf_q.push_back(m_dtf);
    blk_q.push_back(!gate_ok);
    if (m_flt && fault_clr && !fault) m_res = 1;
    else if (pos == 0)                m_res = 0;
    if (fault)          m_flt = 1;
    else if (fault_clr) m_flt = 0;
    if (!en || pos == N - 1) begin
      m_duty = int'(duty_in);
      m_dtr  = int'(dt_rise);
      m_dtf  = int'(dt_fall);
    end
    m_cnt = en ? (pos + 1) % N : 0;
    exp_q.push_back({ps_n, m_flt, ls_n, hs_n, CNT_W'(m_cnt)});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    duty_in = '0; dt_rise = '0; dt_fall = '0;

    //              duty dtr dtf hs_n ls_lo ls_hi
    tbl[0] = '{20, 6,  6,  20, 26, 58};
    tbl[1] = '{55, 6,  6,  55, 61, 58};
    tbl[2] = '{0,  0,  0,  0,  0,  64};
    tbl[3] = '{32, 0,  0,  32, 32, 64};
    tbl[4] = '{63, 15, 15, 63, 78, 49};
    tbl[5] = '{1,  15, 0,  1,  16, 64};
    tbl[6] = '{10, 3,  12, 10, 13, 52};

    // Reset state
    #2;
    check("reset hs", int'(hs_out), 0);
    check("reset ls", int'(ls_out), 0);
    check("reset count", int'(count), 0);
    check("reset ps", int'(period_start), 0);
    check("reset flt", int'(fault_latched), 0);
    @(negedge clk);
    rst = 1'b1;

    // Parked with en=0: no period_start
    step();
    step();
    check("parked count", int'(count), 0);
    check("parked ps", int'(period_start), 0);

    // Table-driven full periods
    foreach (tbl[v]) begin
      start_run(tbl[v].duty, tbl[v].dtr, tbl[v].dtf);
      run_period($sformatf("vec%0d", v), tbl[v].hs_n, tbl[v].ls_lo, tbl[v].ls_hi);
    end

    // Mid-period duty change only takes effect next period
    start_run(20, 6, 6);
    for (int i = 0; i < 2 * N; i++) begin
      int idx;
      step();
      idx = (int'(count) + N - 1) % N;
      if (i < N) begin
        check($sformatf("dchg p0 hs@%0d", idx), int'(hs_out), int'(idx < 20));
        check($sformatf("dchg p0 ls@%0d", idx), int'(ls_out), int'(idx >= 26 && idx < 58));
      end else begin
        check($sformatf("dchg p1 hs@%0d", idx), int'(hs_out), int'(idx < 40));
        check($sformatf("dchg p1 ls@%0d", idx), int'(ls_out), int'(idx >= 46 && idx < 58));
      end
      if (int'(count) == 10 && i < N) duty_in = 6'd40;
    end

    // Fault at count 30, both-high hold at 35, clear at 40, resume at wrap
    start_run(20, 6, 6);
    step();
    wait_count(30);
    check("pre-fault ls", int'(ls_out), 1);
    fault = 1'b1;
    step();
    fault = 1'b0;
    check("fault hs", int'(hs_out), 0);
    check("fault ls", int'(ls_out), 0);
    check("fault latched", int'(fault_latched), 1);
    check("fault count runs", int'(count), 31);
    hold_off_until(35, "fault hold");
    fault = 1'b1;
    fault_clr = 1'b1;
    step();
    fault = 1'b0;
    fault_clr = 1'b0;
    check("fault+clr stays", int'(fault_latched), 1);
    hold_off_until(40, "fault hold2");
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("cleared", int'(fault_latched), 0);
    check("resume hold ls", int'(ls_out), 0);
    hold_off_until(1, "resume hold");
    check("resume hs@0", int'(hs_out), 1);
    check("resume ps@0", int'(period_start), 1);
    run_period("post-resume", 20, 26, 58);

    // en falling mid-period
    wait_count(25);
    en = 1'b0;
    step();
    check("en drop hs", int'(hs_out), 0);
    check("en drop ls", int'(ls_out), 0);
    check("en drop count", int'(count), 0);
    check("en drop ps", int'(period_start), 0);
    check("en drop flt", int'(fault_latched), 0);

    // Asynchronous reset mid-period
    start_run(20, 6, 6);
    step();
    wait_count(16);
    check("pre-rst hs", int'(hs_out), 1);
    #2 rst = 1'b0;
    #1;
    check("async rst hs", int'(hs_out), 0);
    check("async rst ls", int'(ls_out), 0);
    check("async rst count", int'(count), 0);
    check("async rst ps", int'(period_start), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post-rst count", int'(count), 1);
    check("post-rst ps", int'(period_start), 1);
    check("post-rst hs", int'(hs_out), 0);

    // Randomized run against the reference model
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    begin
      int  hs_last, ls_last, ls_last_dtf, blk;
      bit  prev_hs, prev_ls;
      hs_last = -1; ls_last = -1; ls_last_dtf = 0; blk = 0;
      prev_hs = 0; prev_ls = 0;
      for (int i = 1; i <= 10000; i++) begin
        logic [W-1:0] exp_w, act_w;
        int  cdtr, cdtf;
        bit  cblk;
        if ($urandom_range(0, 15) == 0) duty_in = CNT_W'($urandom_range(0, N - 1));
        if ($urandom_range(0, 15) == 0) dt_rise = DT_W'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) dt_fall = DT_W'($urandom_range(0, 15));
        if (en) en = ($urandom_range(0, 299) != 0);
        else    en = ($urandom_range(0, 3) == 0);
        fault     = ($urandom_range(0, 399) == 0);
        fault_clr = ($urandom_range(0, 39) == 0);
        model_step();
        step();
        exp_w = exp_q.pop_front();
        cdtr  = dtr_q.pop_front();
        cdtf  = dtf_q.pop_front();
        cblk  = blk_q.pop_front();
        act_w = {period_start, fault_latched, ls_out, hs_out, count};
        check($sformatf("rand cyc%0d {ps,flt,ls,hs,cnt}", i), int'(act_w), int'(exp_w));
        if (cblk) blk = i;
        if (ls_out && !prev_ls && hs_last > blk)
          check_ge($sformatf("rand cyc%0d hs->ls deadtime", i), i - hs_last - 1, cdtr);
        if (hs_out && !prev_hs && ls_last > blk)
          check_ge($sformatf("rand cyc%0d ls->hs deadtime", i), i - ls_last - 1, ls_last_dtf);
        if (hs_out) hs_last = i;
        if (ls_out) begin
          ls_last = i;
          ls_last_dtf = cdtf;
        end
        prev_hs = hs_out;
        prev_ls = ls_out;
      end
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
